// File: rtl/tb_collector_pkg.sv
// +-----------------------------------------------------------------------+
// | tb_collector_pkg: FSM states, sub-command names, operand parsers.      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

package tb_collector_pkg;

  typedef enum logic [2:0] {
    ST_IDLE          = 3'd0,
    ST_COLLECT       = 3'd1,
    ST_WAIT_CNT      = 3'd2,
    ST_WAIT_CNT_IDLE = 3'd3,
    ST_RESP          = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CMD_START = 3'd0,
    CMD_STOP  = 3'd1,
    CMD_POP   = 3'd2,
    CMD_WAIT  = 3'd3,
    CMD_BAD   = 3'd4
  } cmd_e;

  localparam string C_CMD_START = "START";
  localparam string C_CMD_STOP  = "STOP";
  localparam string C_CMD_POP   = "POP_CHECK";
  localparam string C_CMD_WAIT  = "WAIT_COUNT";

  // Optional 0x prefix; characters that are not hex digits are skipped.
  function automatic logic [63:0] hex_to_vec(input string s);
    logic [63:0] v;
    logic [7:0]  c;
    int          first;
    v     = '0;
    first = 0;
    if (s.len() >= 2 && s.getc(0) == 8'h30 && (s.getc(1) == 8'h78 || s.getc(1) == 8'h58))
      first = 2;
    for (int i = first; i < s.len(); i++) begin
      c = s.getc(i);
      if (c >= 8'h30 && c <= 8'h39)      v = {v[59:0], 4'(c - 8'h30)};
      else if (c >= 8'h61 && c <= 8'h66) v = {v[59:0], 4'(c - 8'h57)};
      else if (c >= 8'h41 && c <= 8'h46) v = {v[59:0], 4'(c - 8'h37)};
    end
    return v;
  endfunction

  function automatic logic [31:0] dec_to_int(input string s);
    logic [31:0] v;
    logic [7:0]  c;
    v = '0;
    for (int i = 0; i < s.len(); i++) begin
      c = s.getc(i);
      if (c >= 8'h30 && c <= 8'h39) v = (v * 32'd10) + 32'(c - 8'h30);
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/collector_fifo.sv
// +-----------------------------------------------------------------------+
// | collector_fifo: show-ahead synchronous FIFO with wrap-bit pointers.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module collector_fifo #(
  parameter int COLLECT_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [COLLECT_WIDTH-1:0] din,
  output logic [COLLECT_WIDTH-1:0] dout,
  output logic                     full,
  output logic                     empty
);

  localparam int C_AW = $clog2(FIFO_DEPTH);

  logic [COLLECT_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [C_AW:0]            r_wr_ptr;
  logic [C_AW:0]            r_rd_ptr;

  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[C_AW] != r_rd_ptr[C_AW]) &&
                 (r_wr_ptr[C_AW-1:0] == r_rd_ptr[C_AW-1:0]);
  assign dout  = r_mem[r_rd_ptr[C_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // The caller guards push against full, allowing push-on-full only with a pop.
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) r_mem[r_wr_ptr[C_AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/data_collector.sv
// +-----------------------------------------------------------------------+
// | data_collector: captures one aliased DUT output channel into a FIFO   |
// | and runs START/STOP/POP_CHECK/WAIT_COUNT sub-commands.                |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module data_collector
  import tb_collector_pkg::*;
#(
  parameter int ARGS_NB       = 5,
  parameter int COLLECT_SIZE  = 5,
  parameter int COLLECT_WIDTH = 32,
  parameter int FIFO_DEPTH    = 16,
  parameter int CNT_WIDTH     = 16,
  parameter bit REPORT_EN     = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  string                    i_collect_alias [COLLECT_SIZE],
  input  logic                     i_sel_collect,
  input  logic                     i_args_valid,
  input  string                    i_args [ARGS_NB],
  input  logic [COLLECT_SIZE-1:0]  i_data_valid,
  input  logic [COLLECT_WIDTH-1:0] i_data [COLLECT_SIZE],
  output logic                     o_collect_done,
  output logic [CNT_WIDTH-1:0]     o_sample_cnt,
  output logic [CNT_WIDTH-1:0]     o_error_cnt,
  output logic                     o_overflow
);

  localparam int C_SEL_W = (COLLECT_SIZE > 1) ? $clog2(COLLECT_SIZE) : 1;

  state_e                   r_state, w_state_nxt, r_ret_state;
  logic [C_SEL_W-1:0]       r_sel, w_alias_idx;
  logic [CNT_WIDTH-1:0]     r_sample_cnt, r_error_cnt, r_wait_n;
  logic [31:0]              r_timer, r_wait_to;
  logic                     r_overflow, w_alias_hit, w_accept, w_in_wait, w_capture;
  logic                     w_flush, w_push, w_pop, w_drop, w_err_inc, w_wait_met, w_wait_to;
  logic                     w_busy_sel, w_pop_bad, w_fifo_full, w_fifo_empty;
  cmd_e                     w_cmd;
  logic [COLLECT_WIDTH-1:0] w_hex, w_fifo_dout;

  // Command decode happens only in the accept cycle, straight off the args bus.
  always_comb begin
    w_alias_hit = 1'b0;
    w_alias_idx = '0;
    for (int i = COLLECT_SIZE - 1; i >= 0; i--) begin
      if (i_collect_alias[i] == i_args[2]) begin
        w_alias_hit = 1'b1;
        w_alias_idx = C_SEL_W'(i);
      end
    end
    if (i_args[1] == C_CMD_START)     w_cmd = CMD_START;
    else if (i_args[1] == C_CMD_STOP) w_cmd = CMD_STOP;
    else if (i_args[1] == C_CMD_POP)  w_cmd = CMD_POP;
    else if (i_args[1] == C_CMD_WAIT) w_cmd = CMD_WAIT;
    else                              w_cmd = CMD_BAD;
    w_hex = COLLECT_WIDTH'(hex_to_vec(i_args[2]));
  end

  assign w_accept   = i_sel_collect && i_args_valid && (r_state == ST_IDLE || r_state == ST_COLLECT);
  assign w_busy_sel = i_sel_collect && i_args_valid && !(r_state == ST_IDLE || r_state == ST_COLLECT);
  assign w_in_wait  = (r_state == ST_WAIT_CNT) || (r_state == ST_WAIT_CNT_IDLE);
  assign w_wait_met = (r_sample_cnt >= r_wait_n);
  assign w_wait_to  = !w_wait_met && (r_wait_to != 32'd0) && ((r_timer + 32'd1) == r_wait_to);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        if (w_accept) begin
          if (w_cmd == CMD_WAIT)
            w_state_nxt = (r_state == ST_COLLECT) ? ST_WAIT_CNT : ST_WAIT_CNT_IDLE;
          else
            w_state_nxt = ST_RESP;
        end
      end
      ST_WAIT_CNT, ST_WAIT_CNT_IDLE: if (w_wait_met || w_wait_to) w_state_nxt = ST_RESP;
      ST_RESP:                       w_state_nxt = r_ret_state;
      default:                       w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture stays live through the RESP cycle of a command issued while collecting.
  always_comb begin
    o_collect_done = (r_state == ST_RESP);
    w_capture      = (r_state == ST_COLLECT) || (r_state == ST_WAIT_CNT) ||
                     ((r_state == ST_RESP) && (r_ret_state == ST_COLLECT));
    w_flush        = w_accept && (w_cmd == CMD_START) && w_alias_hit;
    w_pop          = w_accept && (w_cmd == CMD_POP) && !w_fifo_empty;
    w_pop_bad      = w_accept && (w_cmd == CMD_POP) && (w_fifo_empty || (w_fifo_dout != w_hex));
    w_push         = w_capture && i_data_valid[r_sel] && (!w_fifo_full || w_pop) && !w_flush;
    w_drop         = w_capture && i_data_valid[r_sel] && w_fifo_full && !w_pop && !w_flush;
    w_err_inc      = w_pop_bad || (w_in_wait && w_wait_to) ||
                     (w_accept && (w_cmd == CMD_BAD || (w_cmd == CMD_START && !w_alias_hit)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ret_state  <= ST_IDLE;
      r_sel        <= '0;
      r_sample_cnt <= '0;
      r_error_cnt  <= '0;
      r_overflow   <= 1'b0;
      r_wait_n     <= '0;
      r_wait_to    <= '0;
      r_timer      <= '0;
    end else begin
      if (w_flush) begin
        r_sel        <= w_alias_idx;
        r_sample_cnt <= '0;
        r_overflow   <= 1'b0;
      end else begin
        if (w_push && r_sample_cnt != '1) r_sample_cnt <= r_sample_cnt + 1'b1;
        if (w_drop)                       r_overflow   <= 1'b1;
      end
      if (w_err_inc && r_error_cnt != '1) r_error_cnt <= r_error_cnt + 1'b1;
      if (w_accept) begin
        r_timer   <= '0;
        r_wait_n  <= CNT_WIDTH'(dec_to_int(i_args[2]));
        r_wait_to <= dec_to_int(i_args[3]);
        if (w_cmd == CMD_START)     r_ret_state <= w_alias_hit ? ST_COLLECT : ST_IDLE;
        else if (w_cmd == CMD_STOP) r_ret_state <= ST_IDLE;
        else                        r_ret_state <= r_state;
      end else if (w_in_wait) begin
        r_timer <= r_timer + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (REPORT_EN && rst_n) begin
      if (w_accept && w_cmd == CMD_START && !w_alias_hit)
        $error("data_collector: unknown alias '%s'", i_args[2]);
      if (w_accept && w_cmd == CMD_BAD)
        $error("data_collector: unknown sub-command '%s'", i_args[1]);
      if (w_pop_bad && w_fifo_empty)
        $error("data_collector: POP_CHECK on empty FIFO");
      else if (w_pop_bad)
        $error("data_collector: POP_CHECK expected %0h actual %0h", w_hex, w_fifo_dout);
      if (w_in_wait && w_wait_to)
        $error("data_collector: WAIT_COUNT timeout at %0d samples", r_sample_cnt);
      if (w_busy_sel)
        $warning("data_collector: select ignored while busy");
    end
  end

  collector_fifo #(
    .COLLECT_WIDTH(COLLECT_WIDTH),
    .FIFO_DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .flush(w_flush),
    .push (w_push),
    .pop  (w_pop),
    .din  (i_data[r_sel]),
    .dout (w_fifo_dout),
    .full (w_fifo_full),
    .empty(w_fifo_empty)
  );

  assign o_sample_cnt = r_sample_cnt;
  assign o_error_cnt  = r_error_cnt;
  assign o_overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_data_collector.sv
// +-----------------------------------------------------------------------+
// | tb_data_collector: directed self-checking bench for data_collector.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_data_collector;

  logic        clk;
  logic        rst_n;
  string       alias_s [5];
  logic        sel_collect;
  logic        args_valid;
  string       args_s [5];
  logic [4:0]  data_valid;
  logic [31:0] data [5];
  logic        collect_done;
  logic [15:0] sample_cnt;
  logic [15:0] error_cnt;
  logic        overflow;

  int total = 0;
  int bad   = 0;

  data_collector #(
    .ARGS_NB(5), .COLLECT_SIZE(5), .COLLECT_WIDTH(32),
    .FIFO_DEPTH(16), .CNT_WIDTH(16), .REPORT_EN(1'b0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_collect_alias(alias_s),
    .i_sel_collect  (sel_collect),
    .i_args_valid   (args_valid),
    .i_args         (args_s),
    .i_data_valid   (data_valid),
    .i_data         (data),
    .o_collect_done (collect_done),
    .o_sample_cnt   (sample_cnt),
    .o_error_cnt    (error_cnt),
    .o_overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Presents a command at a negedge; returns at the negedge after the accept edge.
  task automatic cmd(input string c, input string a2, input string a3);
    sel_collect = 1'b1;
    args_valid  = 1'b1;
    args_s[1]   = c;
    args_s[2]   = a2;
    args_s[3]   = a3;
    @(negedge clk);
    sel_collect = 1'b0;
    args_valid  = 1'b0;
  endtask

  task automatic cmd_done(input string tag, input string c, input string a2);
    cmd(c, a2, "");
    check({tag, " done"}, {31'd0, collect_done}, 32'd1);
    @(negedge clk);
    check({tag, " done low"}, {31'd0, collect_done}, 32'd0);
  endtask

  task automatic strobe(input int ch, input logic [31:0] d);
    data_valid[ch] = 1'b1;
    data[ch]       = d;
    @(negedge clk);
    data_valid[ch] = 1'b0;
  endtask

  initial begin
    int cyc;
    alias_s = '{"DIN", "CTRL", "DOUT", "ADDR", "DOUT"};
    args_s  = '{"", "", "", "", ""};
    for (int i = 0; i < 5; i++) data[i] = '0;
    data_valid  = '0;
    sel_collect = 1'b0;
    args_valid  = 1'b0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    check("rst done", {31'd0, collect_done}, 32'd0);
    check("rst cnt", {16'd0, sample_cnt}, 32'd0);
    check("rst err", {16'd0, error_cnt}, 32'd0);
    check("rst ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic capture on the first "DOUT" alias; channel 4 shares the name and is ignored.
    cmd_done("start", "START", "DOUT");
    strobe(2, 32'hA);
    strobe(2, 32'hB);
    strobe(4, 32'h99);
    strobe(2, 32'hC);
    check("cnt abc", {16'd0, sample_cnt}, 32'd3);
    cmd_done("pop a", "POP_CHECK", "A");
    cmd_done("pop b", "POP_CHECK", "0xB");
    cmd_done("pop c", "POP_CHECK", "c");
    check("err abc", {16'd0, error_cnt}, 32'd0);

    // Mismatch, then pop from an empty FIFO.
    strobe(2, 32'h6);
    cmd_done("pop mis", "POP_CHECK", "5");
    check("err mis", {16'd0, error_cnt}, 32'd1);
    cmd_done("pop empty", "POP_CHECK", "5");
    check("err empty", {16'd0, error_cnt}, 32'd2);
    check("cnt 4", {16'd0, sample_cnt}, 32'd4);

    // Overflow, then push and pop together while full.
    cmd_done("restart", "START", "DOUT");
    check("cnt clr", {16'd0, sample_cnt}, 32'd0);
    for (int i = 0; i < 20; i++) strobe(2, 32'(i));
    check("cnt full", {16'd0, sample_cnt}, 32'd16);
    check("ovf set", {31'd0, overflow}, 32'd1);
    data_valid[2] = 1'b1;
    data[2]       = 32'h64;
    cmd("POP_CHECK", "0", "");
    data_valid[2] = 1'b0;
    check("pp done", {31'd0, collect_done}, 32'd1);
    check("pp cnt", {16'd0, sample_cnt}, 32'd17);
    @(negedge clk);
    for (int i = 1; i < 16; i++) cmd_done("drain", "POP_CHECK", $sformatf("%0h", i));
    cmd_done("drain last", "POP_CHECK", "64");
    check("err drain", {16'd0, error_cnt}, 32'd2);
    cmd_done("drain empty", "POP_CHECK", "0");
    check("err drain empty", {16'd0, error_cnt}, 32'd3);

    // WAIT_COUNT met by the 4th of 4 strobes spaced 10 cycles apart.
    cmd_done("start w", "START", "DOUT");
    cmd("WAIT_COUNT", "4", "100");
    for (int k = 0; k < 4; k++) begin
      repeat (9) @(negedge clk);
      check("wait no early done", {31'd0, collect_done}, 32'd0);
      strobe(2, 32'(k));
    end
    check("wait cnt4", {16'd0, sample_cnt}, 32'd4);
    check("wait done pending", {31'd0, collect_done}, 32'd0);
    @(negedge clk);
    check("wait done", {31'd0, collect_done}, 32'd1);
    @(negedge clk);
    check("wait err", {16'd0, error_cnt}, 32'd3);

    // WAIT_COUNT timeout: done follows the 20th edge after accept.
    cmd("WAIT_COUNT", "8", "20");
    cyc = 0;
    while (!collect_done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("timeout cycles", 32'(cyc), 32'd20);
    check("timeout err", {16'd0, error_cnt}, 32'd4);
    @(negedge clk);

    // Asynchronous reset in the middle of an endless WAIT_COUNT.
    cmd_done("start r", "START", "DOUT");
    strobe(2, 32'h55);
    cmd("WAIT_COUNT", "8", "0");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst cnt", {16'd0, sample_cnt}, 32'd0);
    check("arst err", {16'd0, error_cnt}, 32'd0);
    check("arst done", {31'd0, collect_done}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post rst done", {31'd0, collect_done}, 32'd0);
    cmd_done("post rst pop", "POP_CHECK", "55");
    check("post rst flushed", {16'd0, error_cnt}, 32'd1);

    // Unknown alias, unknown command, STOP from IDLE.
    cmd_done("bogus", "START", "BOGUS");
    check("bogus err", {16'd0, error_cnt}, 32'd2);
    strobe(2, 32'h7);
    strobe(2, 32'h8);
    check("bogus no capture", {16'd0, sample_cnt}, 32'd0);
    cmd_done("unknown cmd", "FOO", "");
    check("unknown err", {16'd0, error_cnt}, 32'd3);
    cmd_done("stop idle", "STOP", "");
    check("stop idle err", {16'd0, error_cnt}, 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
